reg_file_dump: RTL and testbench
================================

# reg_file_dump

Sequential read-out engine for the SLC-3 eight-entry, 16-bit register file. On a Start pulse it drives its own read-select into a register-file read port and streams R0 through R7 in order over a valid/ready handshake, tagging each word with its register index. It sits beside the register file and feeds a debug or display consumer (hex display, serial transmitter). It snoops the register-file write strobe so that it never captures a value that is being overwritten in the same cycle.

## Interface
- NUM_REGS, 8: registers scanned, R0..R(NUM_REGS-1).
- DATA_W, 16: register width.
- IDX_W, 3: index width, equal to log2(NUM_REGS).

- Clk  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; forces the reset values below immediately.
- Start  in  1  begin a scan; sampled only in IDLE.
- Rd_Sel  out  IDX_W  read-port select into the register file (SR-style port).
- Rd_Data  in  DATA_W  combinational read data for Rd_Sel.
- Wr_En  in  1  register-file write strobe (LD_REG), snooped.
- Wr_Sel  in  IDX_W  register-file write destination (DR), snooped.
- Out_Valid  out  1  Out_Data, Out_Idx and Out_Last are valid.
- Out_Ready  in  1  consumer accepts the word when Out_Valid && Out_Ready.
- Out_Data  out  DATA_W  captured register value.
- Out_Idx  out  IDX_W  index of the captured register.
- Out_Last  out  1  high with the word for R(NUM_REGS-1).
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: Start=1 -> READ, with idx=0. Start=0 -> stay in IDLE.
- READ: Rd_Sel=idx.
  - Wr_En=1 && Wr_Sel==idx -> stay in READ (stall one cycle) so the post-write value is read.
  - Otherwise capture Rd_Data into Out_Data, set Out_Idx=idx, set Out_Last=(idx==NUM_REGS-1), then go to HOLD.
- HOLD: Out_Valid=1. Out_Data, Out_Idx and Out_Last are held stable until accepted.
  - Accept with Out_Last=0 -> idx+1, go to READ.
  - Accept with Out_Last=1 -> DONE.
  - No accept -> stay in HOLD.
- DONE: Done=1 for one cycle, then IDLE. idx is cleared to 0.
- Start is ignored in every state except IDLE. It is not queued.
- Writes to a register after its capture are not reflected in that scan. The scan is a snapshot per register, not an atomic snapshot of the whole file.
- idx never wraps inside a scan. The increment from NUM_REGS-1 cannot occur.
- Rd_Sel shows idx in every state. It is 0 in IDLE.

## Timing
- Reset values: Out_Valid=0, Out_Data=0, Out_Idx=0, Out_Last=0, Rd_Sel=0, Busy=0, Done=0; state=IDLE; idx=0.
- Start high at edge k: Busy=1 and READ after edge k. Capture occurs at edge k+1. Out_Valid=1 after edge k+1.
- Minimum cost per register is 2 cycles (READ, then HOLD with Ready=1).
- Minimum full scan with Ready tied high: Start, then 16 cycles, then Done in the next cycle. Busy is high for 17 cycles.
- Each write conflict adds exactly one cycle per stall cycle.
- Out_Valid drops in the cycle after acceptance, i.e. the cycle in READ. Words are never back-to-back.
- Reset mid-scan, in any state: immediate return to reset values. No Done pulse. A partially transferred word is discarded.
- Start and Reset asserted together: Reset wins.

## Structure
- Shared package slc3_dbg_pkg holds:
  - the state enum dump_state_t (IDLE, READ, HOLD, DONE);
  - the constants SLC3_NUM_REGS=8 and SLC3_REG_W=16.
- Sub-module: the existing reg_16 holds Out_Data. Its Load is driven by the READ capture condition and its Data_In by Rd_Data.
- Everything else stays in this module:
  - the FSM;
  - the idx counter;
  - the Out_Idx and Out_Last registers.

## Test plan
- Preload R0..R7 = 16'h1000..16'h1007, Ready tied high, pulse Start -> 8 words with Idx 0..7 and Data 16'h1000..16'h1007; Out_Last only on Idx 7; Done exactly 17 cycles after the Start edge.
- Ready low for 5 cycles during the R3 HOLD -> Out_Data=16'h1003 and Idx=3 held stable all 5 cycles; no word skipped or repeated.
- Wr_En=1, Wr_Sel=4, bus=16'hBEEF in the R4 READ cycle -> one stall cycle; emitted word is 16'hBEEF, not 16'h1004.
- Write R2=16'hAAAA after R2 was emitted -> this scan keeps the old R2 value; a second Start gives 16'hAAAA.
- Reset asserted mid-scan during the R5 HOLD -> outputs zero immediately and no Done; a new Start restarts at Idx 0.
- Start pulsed while Busy -> ignored; exactly 8 words and one Done.

Source files
------------

// File: rtl/slc3_dbg_pkg.sv
// Shared definitions for the SLC-3 debug read-out blocks: register file
// geometry and the dump engine state encoding.
package slc3_dbg_pkg;

   localparam int SLC3_NUM_REGS = 8;
   localparam int SLC3_REG_W    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage

// File: rtl/reg_16.sv
// Load-enabled data register with asynchronous active-high clear.
module reg_16 #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] Data_In,
   output logic [WIDTH-1:0] Data_Out
);

   // Capture Data_In whenever Load is high; clear immediately on Reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Data_Out <= '0;
      end else if (Load) begin
         Data_Out <= Data_In;
      end
   end

endmodule

// File: rtl/reg_file_dump.sv
// Streams R0..R(NUM_REGS-1) of the SLC-3 register file over a valid/ready
// port, one word per register, tagged with its index. The engine owns the
// read select of one register-file port and watches the write strobe so a
// register being written in the same cycle is re-read after the write lands.
module reg_file_dump
   import slc3_dbg_pkg::*;
#(
   parameter int NUM_REGS = SLC3_NUM_REGS,
   parameter int DATA_W   = SLC3_REG_W,
   parameter int IDX_W    = $clog2(SLC3_NUM_REGS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic [IDX_W-1:0]  Rd_Sel,
   input  logic [DATA_W-1:0] Rd_Data,
   input  logic              Wr_En,
   input  logic [IDX_W-1:0]  Wr_Sel,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [IDX_W-1:0]  Out_Idx,
   output logic              Out_Last,
   output logic              Busy,
   output logic              Done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   dump_state_t      state;
   dump_state_t      state_next;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_next;
   logic             wr_hit;
   logic             capture;

   // A write to the register currently selected would make Rd_Data stale
   // by the next edge, so the capture is deferred until the write is done.
   assign wr_hit = Wr_En && (Wr_Sel == idx);

   // Next-state, index advance and capture strobe for the scan sequencer.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               state_next = READ;
               idx_next   = '0;
            end
         end
         READ: begin
            if (!wr_hit) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (Out_Ready) begin
               if (Out_Last) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx + 1'b1;
                  state_next = READ;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            idx_next   = '0;
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // State and scan index registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Index tag and last-word flag travel with the captured data word.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Out_Idx  <= '0;
         Out_Last <= 1'b0;
      end else if (capture) begin
         Out_Idx  <= idx;
         Out_Last <= (idx == LAST_IDX);
      end
   end

   reg_16 #(
      .WIDTH (DATA_W)
   ) u_data_reg (
      .Clk      (Clk),
      .Reset    (Reset),
      .Load     (capture),
      .Data_In  (Rd_Data),
      .Data_Out (Out_Data)
   );

   assign Rd_Sel    = idx;
   assign Out_Valid = (state == HOLD);
   assign Busy      = (state != IDLE);
   assign Done      = (state == DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: a behavioural register file drives the
// read port, a scoreboard queue holds the expected words of each scan.
module tb_reg_file_dump;
   import slc3_dbg_pkg::*;

   localparam int NR = 8;
   localparam int DW = 16;
   localparam int IW = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic [IW-1:0] Rd_Sel;
   logic [DW-1:0] Rd_Data;
   logic          Wr_En;
   logic [IW-1:0] Wr_Sel;
   logic [DW-1:0] Wr_Data;
   logic          Out_Valid;
   logic          Out_Ready;
   logic [DW-1:0] Out_Data;
   logic [IW-1:0] Out_Idx;
   logic          Out_Last;
   logic          Busy;
   logic          Done;

   logic [DW-1:0] rf    [NR];
   logic [DW-1:0] model [NR];

   typedef struct packed {
      logic [DW-1:0] d;
      logic [IW-1:0] i;
      logic          l;
   } word_t;

   word_t sb[$];

   int checks   = 0;
   int errors   = 0;
   int words    = 0;
   int done_cnt = 0;

   int            stall_idx  = -1;
   int            conf_idx   = -1;
   int            late_trig  = -1;
   int            late_reg   = -1;
   int            rst_idx    = -1;
   bit            start_busy = 1'b0;
   logic [DW-1:0] conf_data  = '0;
   logic [DW-1:0] late_data  = '0;

   reg_file_dump dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Rd_Sel    (Rd_Sel),
      .Rd_Data   (Rd_Data),
      .Wr_En     (Wr_En),
      .Wr_Sel    (Wr_Sel),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Data  (Out_Data),
      .Out_Idx   (Out_Idx),
      .Out_Last  (Out_Last),
      .Busy      (Busy),
      .Done      (Done)
   );

   always #5 Clk = ~Clk;

   assign Rd_Data = rf[Rd_Sel];

   always @(posedge Clk) begin
      if (Wr_En) rf[Wr_Sel] <= Wr_Data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Output monitor: every valid cycle must show the scoreboard head;
   // the head is retired when the handshake completes at the next edge.
   always @(negedge Clk) begin
      if (!Reset && Out_Valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            chk("word_data", 32'(Out_Data), 32'(sb[0].d));
            chk("word_idx",  32'(Out_Idx),  32'(sb[0].i));
            chk("word_last", 32'(Out_Last), 32'(sb[0].l));
            if (Out_Ready) begin
               void'(sb.pop_front());
               words++;
            end
         end
      end
      if (!Reset && Done) done_cnt++;
   end

   task automatic scan(input string tag, input int exp_busy, input int exp_stall);
      int busy_n    = 0;
      int done_at   = 0;
      int stall_n   = 0;
      int low_n     = 0;
      int n         = 0;
      int w0;
      int d0;
      bit conf_done = 1'b0;
      bit late_done = 1'b0;
      bit reset_hit = 1'b0;
      w0 = words;
      d0 = done_cnt;
      for (int i = 0; i < NR; i++)
         sb.push_back(word_t'{d: model[i], i: IW'(i), l: (i == NR - 1)});
      Start = 1'b1;
      tick();
      while (n < 300) begin
         n++;
         Start     = 1'b0;
         Wr_En     = 1'b0;
         Out_Ready = 1'b1;
         if (Busy) busy_n++;
         if (Done) done_at = busy_n;
         if (Busy && !Out_Valid && !Done && int'(Rd_Sel) == conf_idx) stall_n++;
         if (stall_idx >= 0 && Out_Valid && int'(Out_Idx) == stall_idx && low_n < 5) begin
            Out_Ready = 1'b0;
            low_n++;
            chk({tag, "_hold_data"}, 32'(Out_Data), 32'(model[stall_idx]));
            chk({tag, "_hold_idx"},  32'(Out_Idx),  32'(stall_idx));
         end
         if (conf_idx >= 0 && !conf_done && Busy && !Out_Valid && !Done &&
             int'(Rd_Sel) == conf_idx) begin
            Wr_En     = 1'b1;
            Wr_Sel    = IW'(conf_idx);
            Wr_Data   = conf_data;
            conf_done = 1'b1;
         end
         if (late_trig >= 0 && !late_done && Out_Valid && int'(Out_Idx) == late_trig) begin
            Wr_En           = 1'b1;
            Wr_Sel          = IW'(late_reg);
            Wr_Data         = late_data;
            model[late_reg] = late_data;
            late_done       = 1'b1;
         end
         if (start_busy && (busy_n == 5 || Done)) Start = 1'b1;
         if (rst_idx >= 0 && Out_Valid && int'(Out_Idx) == rst_idx) begin
            Reset = 1'b1;
            #1;
            chk({tag, "_rst_valid"}, 32'(Out_Valid), 32'd0);
            chk({tag, "_rst_data"},  32'(Out_Data),  32'd0);
            chk({tag, "_rst_idx"},   32'(Out_Idx),   32'd0);
            chk({tag, "_rst_last"},  32'(Out_Last),  32'd0);
            chk({tag, "_rst_rdsel"}, 32'(Rd_Sel),    32'd0);
            chk({tag, "_rst_busy"},  32'(Busy),      32'd0);
            chk({tag, "_rst_done"},  32'(Done),      32'd0);
            sb.delete();
            reset_hit = 1'b1;
            break;
         end
         if (!Busy && busy_n > 0) break;
         tick();
      end
      Start     = 1'b0;
      Wr_En     = 1'b0;
      Out_Ready = 1'b1;
      if (rst_idx >= 0) begin
         chk({tag, "_reset_reached"}, 32'(reset_hit), 32'd1);
         tick();
         Reset = 1'b0;
         for (int i = 0; i < 4; i++) tick();
         chk({tag, "_no_done"},   32'(done_cnt - d0), 32'd0);
         chk({tag, "_idle_busy"}, 32'(Busy),          32'd0);
         sb.delete();
      end else begin
         chk({tag, "_busy_cycles"}, 32'(busy_n),        32'(exp_busy));
         chk({tag, "_done_at"},     32'(done_at),       32'(exp_busy));
         chk({tag, "_words"},       32'(words - w0),    32'(NR));
         chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
         chk({tag, "_sb_empty"},    32'(sb.size()),     32'd0);
         if (conf_idx >= 0) chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
         if (stall_idx >= 0) chk({tag, "_ready_low"}, 32'(low_n), 32'd5);
      end
   endtask

   initial begin
      Reset     = 1'b1;
      Start     = 1'b0;
      Wr_En     = 1'b0;
      Wr_Sel    = '0;
      Wr_Data   = '0;
      Out_Ready = 1'b1;
      tick();
      tick();
      chk("reset_valid", 32'(Out_Valid), 32'd0);
      chk("reset_data",  32'(Out_Data),  32'd0);
      chk("reset_idx",   32'(Out_Idx),   32'd0);
      chk("reset_last",  32'(Out_Last),  32'd0);
      chk("reset_rdsel", 32'(Rd_Sel),    32'd0);
      chk("reset_busy",  32'(Busy),      32'd0);
      chk("reset_done",  32'(Done),      32'd0);
      Reset = 1'b0;

      for (int i = 0; i < NR; i++) begin
         Wr_En    = 1'b1;
         Wr_Sel   = IW'(i);
         Wr_Data  = 16'h1000 + 16'(i);
         model[i] = 16'h1000 + 16'(i);
         tick();
      end
      Wr_En = 1'b0;
      tick();
      chk("idle_after_preload", 32'(Busy), 32'd0);

      scan("basic", 17, 0);

      stall_idx = 3;
      scan("ready_stall", 22, 0);
      stall_idx = -1;

      conf_idx  = 4;
      conf_data = 16'hBEEF;
      model[4]  = 16'hBEEF;
      scan("wr_conflict", 18, 2);
      conf_idx  = -1;

      late_trig = 3;
      late_reg  = 2;
      late_data = 16'hAAAA;
      scan("late_write", 17, 0);
      late_trig = -1;

      scan("rescan", 17, 0);

      rst_idx = 5;
      scan("mid_reset", 0, 0);
      rst_idx = -1;

      scan("restart", 17, 0);

      start_busy = 1'b1;
      scan("start_busy", 17, 0);
      start_busy = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("start_not_queued", 32'(Busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
